md_unit_arbiter: RTL and testbench

Controller that shares one iterative 32-bit multiply/divide unit (Reset/Run/Ready protocol, 64-bit Product) between two requesters. It arbitrates round-robin, performs the unit's clear→run→wait-Ready sequence on behalf of the winner, and returns the 64-bit result with a one-cycle response pulse. It sits between the CPU-side requesters and the shared unit, so no requester drives the unit's Reset or Run directly.

---
 rtl/md_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/md_unit_arbiter.sv | 120 ++++++++++++
 tb/tb_md_unit_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_arb_pkg.sv
// Shared definitions for the multiply/divide unit arbiter: state encoding,
// default sizing and the requester ID type.
package md_arb_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int TIMEOUT_DEF = 127;

   typedef logic req_id_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CLEAR  = 3'd1;
   localparam state_t ST_SETTLE = 3'd2;
   localparam state_t ST_RUN    = 3'd3;
   localparam state_t ST_RESP   = 3'd4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a
// tie and moves to the other side whenever a grant is accepted.
module rr_arbiter2
   import md_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t ptr;

   always_comb begin
      gnt    = '0;
      gnt_id = 1'b0;
      if (en) begin
         gnt_id = (req[0] && req[1]) ? ptr : req[1];
         if (|req) gnt[gnt_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (accept && en && |gnt)
         ptr <= ~gnt_id;
   end

endmodule

// File: rtl/md_unit_arbiter.sv
// Shares one iterative multiply/divide unit between two requesters: arbitrates,
// runs the unit's clear/run/ready handshake and returns the 64-bit product.
module md_unit_arbiter
   import md_arb_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               Reset_n,
   input  logic               Req0_valid,
   input  logic [WIDTH-1:0]   Req0_a,
   input  logic [WIDTH-1:0]   Req0_b,
   output logic               Req0_ready,
   input  logic               Req1_valid,
   input  logic [WIDTH-1:0]   Req1_a,
   input  logic [WIDTH-1:0]   Req1_b,
   output logic               Req1_ready,
   output logic               Rsp0_valid,
   output logic [2*WIDTH-1:0] Rsp0_data,
   output logic               Rsp0_err,
   output logic               Rsp1_valid,
   output logic [2*WIDTH-1:0] Rsp1_data,
   output logic               Rsp1_err,
   output logic               Unit_Reset,
   output logic               Unit_Run,
   output logic [WIDTH-1:0]   Unit_A,
   output logic [WIDTH-1:0]   Unit_B,
   input  logic               Unit_Ready,
   input  logic [2*WIDTH-1:0] Unit_Product,
   output logic               Busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t             state;
   req_id_t            owner;
   req_id_t            gnt_id;
   logic [1:0]         gnt;
   logic               accept;
   logic               ready_q;
   logic               ready_rise;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] res_data;
   logic               res_err;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (Reset_n),
      .en     (state == ST_IDLE),
      .req    ({Req1_valid, Req0_valid}),
      .accept (accept),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Grants only exist for valid requesters, so any grant is an accept.
   assign accept     = |gnt;
   assign Req0_ready = gnt[0];
   assign Req1_ready = gnt[1];
   assign ready_rise = Unit_Ready && !ready_q;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         owner    <= 1'b0;
         Unit_A   <= '0;
         Unit_B   <= '0;
         res_data <= '0;
         res_err  <= 1'b0;
         ready_q  <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  Unit_A <= gnt_id ? Req1_a : Req0_a;
                  Unit_B <= gnt_id ? Req1_b : Req0_b;
                  owner  <= gnt_id;
                  state  <= ST_CLEAR;
               end
            end
            ST_CLEAR: state <= ST_SETTLE;
            ST_SETTLE: begin
               cnt     <= '0;
               ready_q <= 1'b0;
               state   <= ST_RUN;
            end
            ST_RUN: begin
               ready_q <= Unit_Ready;
               if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
               // A Ready that is already high without a rising edge is stale.
               if (ready_rise) begin
                  res_data <= Unit_Product;
                  res_err  <= 1'b0;
                  state    <= ST_RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  res_data <= '0;
                  res_err  <= 1'b1;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign Unit_Reset = (state == ST_CLEAR);
   assign Unit_Run   = (state == ST_RUN);
   assign Busy       = (state != ST_IDLE);

   assign Rsp0_valid = (state == ST_RESP) && !owner;
   assign Rsp1_valid = (state == ST_RESP) && owner;
   assign Rsp0_data  = Rsp0_valid ? res_data : '0;
   assign Rsp1_data  = Rsp1_valid ? res_data : '0;
   assign Rsp0_err   = Rsp0_valid && res_err;
   assign Rsp1_err   = Rsp1_valid && res_err;

endmodule

// File: tb/tb_md_unit_arbiter.sv
// Directed bench for md_unit_arbiter with a behavioural multiply unit whose
// Ready latency is set per transaction (0 = never ready).
module tb_md_unit_arbiter;

   localparam int W  = 32;
   localparam int TO = 127;

   logic          clk = 1'b0;
   logic          Reset_n;
   logic          Req0_valid, Req1_valid;
   logic [W-1:0]  Req0_a, Req0_b, Req1_a, Req1_b;
   logic          Req0_ready, Req1_ready;
   logic          Rsp0_valid, Rsp1_valid, Rsp0_err, Rsp1_err;
   logic [2*W-1:0] Rsp0_data, Rsp1_data;
   logic          Unit_Reset, Unit_Run, Unit_Ready, Busy;
   logic [W-1:0]  Unit_A, Unit_B;
   logic [2*W-1:0] Unit_Product;

   int checks = 0;
   int errors = 0;
   int mdl_dly = 0;
   int run_cnt;

   always #5 clk = ~clk;

   md_unit_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .Reset_n(Reset_n),
      .Req0_valid(Req0_valid), .Req0_a(Req0_a), .Req0_b(Req0_b), .Req0_ready(Req0_ready),
      .Req1_valid(Req1_valid), .Req1_a(Req1_a), .Req1_b(Req1_b), .Req1_ready(Req1_ready),
      .Rsp0_valid(Rsp0_valid), .Rsp0_data(Rsp0_data), .Rsp0_err(Rsp0_err),
      .Rsp1_valid(Rsp1_valid), .Rsp1_data(Rsp1_data), .Rsp1_err(Rsp1_err),
      .Unit_Reset(Unit_Reset), .Unit_Run(Unit_Run), .Unit_A(Unit_A), .Unit_B(Unit_B),
      .Unit_Ready(Unit_Ready), .Unit_Product(Unit_Product), .Busy(Busy)
   );

   // Unit model: Ready rises mdl_dly clock edges after Run is first seen.
   always @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Unit_Ready   <= 1'b0;
         Unit_Product <= '0;
         run_cnt      <= 0;
      end else if (Unit_Reset || !Unit_Run) begin
         Unit_Ready <= 1'b0;
         run_cnt    <= 0;
      end else begin
         run_cnt <= run_cnt + 1;
         if (mdl_dly != 0 && run_cnt == mdl_dly - 1) begin
            Unit_Ready   <= 1'b1;
            Unit_Product <= 64'(Unit_A) * 64'(Unit_B);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input int id, input string nm);
      int n = 0;
      #1;
      while (!(id != 0 ? Req1_ready : Req0_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({nm, " grant"}, 64'(id != 0 ? Req1_ready : Req0_ready), 64'd1);
   endtask

   task automatic run_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int dly, input logic [63:0] exp_d, input logic exp_e,
                          input string nm);
      int n;
      mdl_dly = dly;
      if (id == 0) begin Req0_valid = 1'b1; Req0_a = a; Req0_b = b; end
      else         begin Req1_valid = 1'b1; Req1_a = a; Req1_b = b; end
      wait_ready(id, nm);
      @(negedge clk);
      Req0_valid = 1'b0;
      Req1_valid = 1'b0;
      chk({nm, " clear"}, {62'd0, Unit_Reset, Unit_Run}, 64'b10);
      chk({nm, " unit A"}, 64'(Unit_A), 64'(a));
      chk({nm, " unit B"}, 64'(Unit_B), 64'(b));
      @(negedge clk);
      chk({nm, " settle"}, {62'd0, Unit_Reset, Unit_Run}, 64'b00);
      @(negedge clk);
      n = 0;
      while (Unit_Run && n < 400) begin
         n++; @(negedge clk);
      end
      chk({nm, " run cycles"}, 64'(n), 64'(dly != 0 ? dly + 1 : TO));
      if (id == 0) begin
         chk({nm, " rsp valid"}, {62'd0, Rsp1_valid, Rsp0_valid}, 64'b01);
         chk({nm, " data"}, Rsp0_data, exp_d);
         chk({nm, " err"}, 64'(Rsp0_err), 64'(exp_e));
         chk({nm, " other data"}, Rsp1_data, 64'd0);
      end else begin
         chk({nm, " rsp valid"}, {62'd0, Rsp1_valid, Rsp0_valid}, 64'b10);
         chk({nm, " data"}, Rsp1_data, exp_d);
         chk({nm, " err"}, 64'(Rsp1_err), 64'(exp_e));
         chk({nm, " other data"}, Rsp0_data, 64'd0);
      end
      @(negedge clk);
      chk({nm, " idle"}, {61'd0, Rsp1_valid, Rsp0_valid, Busy}, 64'd0);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      Req0_valid = 1'b0;
      Req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      int          id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int          dly;
      logic [63:0] d;
      logic        e;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int n;
      logic bad;

      tbl[0] = '{0, 32'd7,          32'd6,          33, 64'd42,                 1'b0};
      tbl[1] = '{1, 32'd3,          32'd5,          2,  64'd15,                 1'b0};
      tbl[2] = '{0, 32'h55,         32'h2,          0,  64'd0,                  1'b1};
      tbl[3] = '{0, 32'd3,          32'd5,          5,  64'd15,                 1'b0};
      tbl[4] = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   1,  64'hFFFFFFFE00000001,   1'b0};
      tbl[5] = '{0, 32'h12345678,   32'h10,         7,  64'h123456780,          1'b0};
      tbl[6] = '{1, 32'd0,          32'hDEADBEEF,   1,  64'd0,                  1'b0};

      Reset_n = 1'b0;
      Req0_valid = 1'b0; Req1_valid = 1'b0;
      Req0_a = '0; Req0_b = '0; Req1_a = '0; Req1_b = '0;
      #1;
      chk("reset ctrl", {55'd0, Unit_Reset, Unit_Run, Busy, Rsp0_valid, Rsp1_valid,
                         Rsp0_err, Rsp1_err, Req0_ready, Req1_ready}, 64'd0);
      chk("reset operands", {Unit_A, Unit_B}, 64'd0);
      repeat (2) @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].d, tbl[i].e,
                 $sformatf("vec%0d", i));

      // Both requesters held valid from reset: grants must alternate 0,1,0,1.
      do_reset();
      mdl_dly = 3;
      Req0_a = 32'd2; Req0_b = 32'd3; Req1_a = 32'd4; Req1_b = 32'd5;
      Req0_valid = 1'b1; Req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         #1;
         while (!(Req0_ready || Req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
         end
         chk($sformatf("rr grant %0d", k), {62'd0, Req1_ready, Req0_ready},
             (k % 2 != 0) ? 64'b10 : 64'b01);
         n = 0;
         @(negedge clk); #1;
         while (!(Rsp0_valid || Rsp1_valid) && n < 100) begin
            @(negedge clk); #1; n++;
         end
         chk($sformatf("rr rsp %0d", k), {62'd0, Rsp1_valid, Rsp0_valid},
             (k % 2 != 0) ? 64'b10 : 64'b01);
         chk($sformatf("rr data %0d", k), Rsp0_data | Rsp1_data,
             (k % 2 != 0) ? 64'd20 : 64'd6);
         @(negedge clk);
      end
      Req0_valid = 1'b0; Req1_valid = 1'b0;
      @(negedge clk);

      // Req1 arrives while req0 is running: held off until IDLE.
      mdl_dly = 10;
      Req0_valid = 1'b1; Req0_a = 32'd9; Req0_b = 32'd9;
      wait_ready(0, "late req0");
      @(negedge clk);
      Req0_valid = 1'b0;
      n = 0;
      while (!Unit_Run && n < 10) begin @(negedge clk); n++; end
      Req1_valid = 1'b1; Req1_a = 32'd11; Req1_b = 32'd2;
      #1;
      bad = 1'b0; n = 0;
      while (!Rsp0_valid && n < 100) begin
         if (Req1_ready) bad = 1'b1;
         @(negedge clk); #1; n++;
      end
      if (Req1_ready) bad = 1'b1;
      chk("late req1 held off", 64'(bad), 64'd0);
      chk("late req0 data", Rsp0_data, 64'd81);
      @(negedge clk); #1;
      chk("late req1 ready after rsp", 64'(Req1_ready), 64'd1);
      @(negedge clk);
      Req1_valid = 1'b0;
      chk("late req1 clear", {62'd0, Unit_Reset, Unit_Run}, 64'b10);
      chk("late req1 unit A", 64'(Unit_A), 64'd11);
      n = 0;
      while (!Rsp1_valid && n < 100) begin @(negedge clk); n++; end
      chk("late req1 data", Rsp1_data, 64'd22);
      @(negedge clk);

      // Reset in the middle of RUN abandons the transaction silently.
      mdl_dly = 0;
      Req0_valid = 1'b1; Req0_a = 32'd5; Req0_b = 32'd5;
      wait_ready(0, "abort req0");
      @(negedge clk);
      Req0_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort in run", 64'(Unit_Run), 64'd1);
      Reset_n = 1'b0;
      #1;
      chk("abort outputs", {55'd0, Unit_Reset, Unit_Run, Busy, Rsp0_valid, Rsp1_valid,
                            Rsp0_err, Rsp1_err, Req0_ready, Req1_ready}, 64'd0);
      chk("abort operands", {Unit_A, Unit_B}, 64'd0);
      bad = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (Rsp0_valid || Rsp1_valid || Busy) bad = 1'b1;
      end
      Reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (Rsp0_valid || Rsp1_valid || Busy) bad = 1'b1;
      end
      chk("abort no rsp", 64'(bad), 64'd0);
      run_txn(1, 32'd6, 32'd7, 4, 64'd42, 1'b0, "post-reset req1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
